pinwheel_mregfile: RTL and testbench

PINWHEEL_MREGFILE -- requirements
Module: pinwheel_mregfile

---
 rtl/pinwheel_mregfile.sv | 125 ++++++++++++
 tb/tb_pinwheel_mregfile.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pinwheel_mregfile.sv
// Multi-hart register file: RPORTS registered read ports, one write port,
// write-first bypass, hardwired-zero register 0 per hart, post-reset clear sweep.
module pinwheel_mregfile #(
    parameter  int WIDTH  = 32,
    parameter  int HARTS  = 4,
    parameter  int REGS   = 32,
    parameter  int RPORTS = 2,
    localparam int DEPTH  = HARTS * REGS,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RPORTS*AW-1:0]    raddr,
    output logic [RPORTS*WIDTH-1:0] rdata,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    wren,
    output logic                    ready
);

    localparam int          RI   = $clog2(REGS);
    localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ready_q;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  wdata_q;
    logic              wreg_nz;

    assign wreg_nz = |waddr[RI-1:0];

    // State register, sweep counter and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
        end
    end

    // Next state and the single shared array write port: the sweep owns it
    // in CLEAR, the external write owns it in RUN.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[AW-1:0];
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = wren && wreg_nz;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Bypass data is common to all ports; only the per-port select differs.
    always_ff @(posedge clk) begin
        wdata_q <= wdata;
    end

    assign ready = ready_q;

    for (genvar p = 0; p < RPORTS; p++) begin : g_port
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] mem [DEPTH];
        logic [WIDTH-1:0] ram_q;
        logic             zero_q;
        logic             byp_q;

        assign ra = raddr[p*AW +: AW];

        // One array copy per read port, all written identically.
        always_ff @(posedge clk) begin
            // NOTE: the array has no reset so it maps onto block RAM; the
            // CLEAR sweep zeroes it instead.
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
            ram_q <= mem[ra];
        end

        // Output selects are resettable so rdata drops to 0 asynchronously
        // even though the RAM output register cannot be reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zero_q <= 1'b1;
                byp_q  <= 1'b0;
            end else begin
                zero_q <= (state_q == CLEAR) || (ra[RI-1:0] == '0);
                byp_q  <= (state_q == RUN) && wren && wreg_nz && (ra == waddr);
            end
        end

        assign rdata[p*WIDTH +: WIDTH] = zero_q ? '0 : (byp_q ? wdata_q : ram_q);
    end

endmodule

// File: tb/tb_pinwheel_mregfile.sv
// Self-checking bench for pinwheel_mregfile: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_pinwheel_mregfile;

    localparam int W  = 32;
    localparam int AW = 7;
    localparam int N  = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*AW-1:0]   raddr;
    logic [2*W-1:0]    rdata;
    logic [AW-1:0]     waddr = '0;
    logic [W-1:0]      wdata = '0;
    logic              wren = 1'b0;
    logic              ready;

    logic [AW-1:0]     ra [2];
    logic [W-1:0]      rd0, rd1;
    logic [W-1:0]      model [N];

    int passed = 0;
    int total  = 0;

    assign raddr = {ra[1], ra[0]};
    assign rd0   = rdata[W-1:0];
    assign rd1   = rdata[2*W-1:W];

    always #5 clk = ~clk;

    pinwheel_mregfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (raddr),
        .rdata (rdata),
        .waddr (waddr),
        .wdata (wdata),
        .wren  (wren),
        .ready (ready)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // What a RUN-mode read of address a must return after the coming edge.
    function automatic logic [W-1:0] ref_read(input logic [AW-1:0] a);
        if (a % 32 == 0)               return '0;
        if (wren && waddr == a)        return wdata;
        return model[a];
    endfunction

    task automatic tick_check(input string tag);
        logic [W-1:0] e0, e1;
        e0 = ref_read(ra[0]);
        e1 = ref_read(ra[1]);
        @(posedge clk); #1;
        if (wren && (waddr % 32 != 0)) model[waddr] = wdata;
        check({tag, "_p0"}, rd0, e0);
        check({tag, "_p1"}, rd1, e1);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1 || n == 64) begin
                check({tag, "_clear_rd0"}, rd0, '0);
                check({tag, "_clear_rd1"}, rd1, '0);
            end
        end
        check({tag, "_cycles"}, W'(n), W'(N));
        for (int i = 0; i < N; i++) model[i] = '0;
        wren = 1'b0;
    endtask

    task automatic sweep_all(input string tag);
        wren = 1'b0;
        for (int a = 0; a < N; a++) begin
            ra[0] = AW'(a);
            ra[1] = AW'(N - 1 - a);
            tick_check(tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        ra[0] = '0;
        ra[1] = '0;
        for (int i = 0; i < N; i++) model[i] = '0;

        #12;
        check("rst_ready", W'(ready), '0);
        check("rst_rd0", rd0, '0);
        check("rst_rd1", rd1, '0);

        // External write during CLEAR must be ignored.
        wren  = 1'b1;
        waddr = 7'h03;
        wdata = 32'hAAAA5555;
        ra[0] = 7'h03;
        ra[1] = 7'h25;
        wait_ready("boot");
        check("boot_ready", W'(ready), 32'd1);

        sweep_all("sweep0");
        ra[0] = 7'h03;
        tick_check("clearwr");
        check("clearwr_lit", rd0, '0);

        // Plain write then read.
        wren = 1'b1; waddr = 7'h25; wdata = 32'hDEADBEEF; ra[0] = 7'h00; ra[1] = 7'h00;
        tick_check("wr25");
        wren = 1'b0; ra[0] = 7'h25; ra[1] = 7'h45;
        tick_check("rd25");
        check("rd25_lit", rd0, 32'hDEADBEEF);
        check("rd45_lit", rd1, '0);

        // Write-first bypass on both ports.
        wren = 1'b1; waddr = 7'h0A; wdata = 32'h12345678; ra[0] = 7'h0A; ra[1] = 7'h0A;
        tick_check("byp0a");
        check("byp0a_lit0", rd0, 32'h12345678);
        check("byp0a_lit1", rd1, 32'h12345678);
        wren = 1'b0;
        tick_check("hold0a");

        // Register 0 of a hart discards writes and reads zero.
        wren = 1'b1; waddr = 7'h20; wdata = 32'hFFFFFFFF; ra[0] = 7'h20; ra[1] = 7'h25;
        tick_check("zr_same");
        check("zr_same_lit", rd0, '0);
        wren = 1'b0;
        tick_check("zr_next");
        check("zr_next_lit", rd0, '0);

        // Random traffic with frequent read/write address collisions.
        for (int i = 0; i < 500; i++) begin
            wren  = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, N - 1));
            wdata = $urandom;
            for (int p = 0; p < 2; p++)
                ra[p] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, N - 1));
            tick_check("rand");
        end

        // Make sure plenty of entries hold nonzero data, then reset mid-cycle.
        for (int a = 1; a < N; a++) begin
            wren = 1'b1; waddr = AW'(a); wdata = 32'h5A000000 | a;
            ra[0] = AW'(a); ra[1] = 7'h25;
            tick_check("fill");
        end
        wren = 1'b0; ra[0] = 7'h25; ra[1] = 7'h7F;
        tick_check("prereset");
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", W'(ready), '0);
        check("midrst_rd0", rd0, '0);
        check("midrst_rd1", rd1, '0);
        wait_ready("reboot");
        sweep_all("sweep1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
